// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding and
// frame-timing constants.
package uart_rx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10;

    // 8 data bits plus the stop bit are clocked into the external shift register
    localparam int NUM_STROBES = 9;

    typedef enum logic [1:0] {
        IDLE,
        START_CHK,
        RECV,
        STOP_CHK
    } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Baud counter: wraps every CLKS_PER_BIT cycles and ticks at the middle of
// each bit period, measured from the cycle after clear is released.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // A tick at count CLKS_PER_BIT/2-1 lands on cycle CLKS_PER_BIT/2 after the edge
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign bit_tick = enable && (cnt == CNT_MID);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: detects the start edge, strobes the external 9-bit
// shift register at mid-bit, and tracks buffer-ready, framing and overrun status.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic stop_bit,
    input  logic data_read,
    output logic shift_strobe,
    output logic load_buffer,
    output logic rx_data_ready,
    output logic framing_error,
    output logic overrun_error
);

    localparam logic [3:0] LAST_BIT = 4'(NUM_STROBES - 1);

    rx_state_t  state;
    rx_state_t  state_next;
    logic [3:0] bit_cnt;
    logic       line_p0;
    logic       line_p1;
    logic       line_p2;
    logic       start_edge;
    logic       timer_enable;
    logic       timer_clear;
    logic       bit_tick;
    logic       set_framing;

    // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized value
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_p0 <= 1'b1;
            line_p1 <= 1'b1;
            line_p2 <= 1'b1;
        end else begin
            line_p0 <= serial_in;
            line_p1 <= line_p0;
            line_p2 <= line_p1;
        end
    end

    assign start_edge = line_p2 & ~line_p1;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .enable  (timer_enable),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_enable = 1'b0;
        timer_clear  = 1'b0;
        shift_strobe = 1'b0;
        load_buffer  = 1'b0;
        set_framing  = 1'b0;
        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (start_edge) begin
                    state_next = START_CHK;
                end
            end
            START_CHK: begin
                timer_enable = 1'b1;
                // Line back high at mid start bit means a glitch, not a frame
                if (bit_tick) begin
                    state_next = line_p1 ? IDLE : RECV;
                end
            end
            RECV: begin
                timer_enable = 1'b1;
                if (bit_tick) begin
                    shift_strobe = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP_CHK;
                    end
                end
            end
            STOP_CHK: begin
                load_buffer = stop_bit;
                set_framing = ~stop_bit;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
        end else if (shift_strobe) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_ready <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (load_buffer) begin
                rx_data_ready <= 1'b1;
            end else if (data_read) begin
                rx_data_ready <= 1'b0;
            end

            // A simultaneous read consumes the old byte, so nothing was overrun
            if (load_buffer && !data_read) begin
                if (rx_data_ready) begin
                    overrun_error <= 1'b1;
                end
            end else if (data_read && !load_buffer) begin
                overrun_error <= 1'b0;
            end

            if (set_framing) begin
                framing_error <= 1'b1;
            end else if (state == IDLE && start_edge) begin
                framing_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus queues expected strobe cycles and
// loaded bytes; a negedge monitor pops and compares as the DUT produces them.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int CPB = 10;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        logic       ovr;
    } load_exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic serial_in = 1'b1;
    logic data_read = 1'b0;
    logic stop_bit;
    logic shift_strobe;
    logic load_buffer;
    logic rx_data_ready;
    logic framing_error;
    logic overrun_error;

    logic [8:0] sr = '1;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         strobe_q[$];
    load_exp_t  load_q[$];
    load_exp_t  le;
    logic       chk_pending = 1'b0;
    logic       chk_ovr = 1'b0;

    always #5 clk = ~clk;

    // Receive shift register model feeding stop_bit back to the DUT
    assign stop_bit = sr[8];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (shift_strobe) sr <= {serial_in, sr[8:1]};
    end

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .stop_bit     (stop_bit),
        .data_read    (data_read),
        .shift_strobe (shift_strobe),
        .load_buffer  (load_buffer),
        .rx_data_ready(rx_data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (chk_pending) begin
            check("rdy_after_load", 32'(rx_data_ready), 1);
            check("ovr_after_load", 32'(overrun_error), 32'(chk_ovr));
            check("fe_after_load", 32'(framing_error), 0);
            chk_pending = 1'b0;
        end
        if (shift_strobe) begin
            check("strobe_expected", 32'(strobe_q.size() != 0), 1);
            if (strobe_q.size() != 0) check("strobe_cycle", cyc, strobe_q.pop_front());
        end
        if (load_buffer) begin
            check("load_expected", 32'(load_q.size() != 0), 1);
            if (load_q.size() != 0) begin
                le = load_q.pop_front();
                check("load_cycle", cyc, le.cyc);
                check("load_data", 32'(sr[7:0]), 32'(le.data));
                chk_pending = 1'b1;
                chk_ovr = le.ovr;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start edge E lands two cycles after the start bit is driven (synchronizer)
    task automatic send_frame(input logic [7:0] data, input logic stop, input int n_strobes,
                              input logic exp_load, input logic exp_ovr,
                              input logic read_at_load, input logic chk_fe_clear);
        int e;
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        @(negedge clk);
        e = cyc + 2;
        for (int k = 0; k < n_strobes; k++) strobe_q.push_back(e + CPB / 2 + (k + 1) * CPB);
        if (exp_load) load_q.push_back('{data, e + CPB / 2 + 9 * CPB + 1, exp_ovr});
        for (int b = 0; b < 10; b++) begin
            serial_in = bits[b];
            for (int c = 0; c < CPB; c++) begin
                if (b == 0 && chk_fe_clear && c == 2) check("fe_held_at_edge", 32'(framing_error), 1);
                if (b == 0 && chk_fe_clear && c == 3) check("fe_cleared_after_edge", 32'(framing_error), 0);
                if (b == 9 && read_at_load && c == 8) data_read = 1'b1;
                if (b == 9 && read_at_load && c == 9) data_read = 1'b0;
                @(negedge clk);
            end
        end
        serial_in = 1'b1;
    endtask

    task automatic read_byte();
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        check("rdy_cleared_by_read", 32'(rx_data_ready), 0);
        check("ovr_cleared_by_read", 32'(overrun_error), 0);
    endtask

    task automatic glitch();
        @(negedge clk);
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_in_start_chk", 32'(dut.state), 32'(START_CHK));
        @(negedge clk);
        check("glitch_back_idle", 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("rst_shift_strobe", 32'(shift_strobe), 0);
        check("rst_load_buffer", 32'(load_buffer), 0);
        check("rst_rdy", 32'(rx_data_ready), 0);
        check("rst_fe", 32'(framing_error), 0);
        check("rst_ovr", 32'(overrun_error), 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_sync", 32'(dut.line_p1), 1);
        @(negedge clk);
        n_rst = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        check("a5_fe", 32'(framing_error), 0);
        check("a5_ovr", 32'(overrun_error), 0);
        read_byte();
        idle(5);

        glitch();
        idle(10);
        check("glitch_rdy", 32'(rx_data_ready), 0);
        check("glitch_fe", 32'(framing_error), 0);
        check("glitch_ovr", 32'(overrun_error), 0);

        send_frame(8'h3C, 1'b0, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        check("framing_set", 32'(framing_error), 1);
        check("framing_no_rdy", 32'(rx_data_ready), 0);
        idle(5);
        send_frame(8'h5A, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(5);

        send_frame(8'h81, 1'b1, 9, 1'b1, 1'b1, 1'b0, 1'b0);
        read_byte();
        idle(5);

        send_frame(8'h11, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        send_frame(8'hF0, 1'b1, 9, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(5);

        // Reset mid-frame at E+50; upper data bits are 1 so no false edge follows
        fork
            send_frame(8'hF8, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                @(negedge clk);
                repeat (52) @(negedge clk);
                n_rst = 1'b0;
                #1;
                check("midrst_shift_strobe", 32'(shift_strobe), 0);
                check("midrst_load_buffer", 32'(load_buffer), 0);
                check("midrst_rdy", 32'(rx_data_ready), 0);
                check("midrst_fe", 32'(framing_error), 0);
                check("midrst_ovr", 32'(overrun_error), 0);
                check("midrst_state", 32'(dut.state), 32'(IDLE));
                check("midrst_bit_cnt", 32'(dut.bit_cnt), 0);
                @(negedge clk);
                n_rst = 1'b1;
            end
        join
        idle(5);

        send_frame(8'hC3, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        read_byte();
        idle(5);

        check("strobe_queue_drained", strobe_q.size(), 0);
        check("load_queue_drained", load_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
